pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised hazard and forwarding controller for the five-stage pipelined CPU. It keeps its own scoreboard of in-flight destination registers across the EX, MEM and WB stages. From that scoreboard it drives EX-stage forwarding selects, register-file bypass, load-use stall, and a taken-branch flush of configurable depth. It also keeps saturating performance counters for stall and flush cycles. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and replaces their unconditional write enables.

## Interface
Parameters:
- REG_AW, 5, register address width; register 0 is hard-wired zero.
- FLUSH_DEPTH, 3, number of younger stages squashed on a taken branch; legal values 1..3.
- CNT_W, 16, width of the performance counters.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- id_valid_i  in  1  the instruction in ID is valid.
- id_rs_i / id_rt_i  in  REG_AW  source registers of the ID instruction.
- id_uses_rs_i / id_uses_rt_i  in  1  the ID instruction reads rs / rt.
- id_dst_i  in  REG_AW  destination register of the ID instruction (after RegDst mux).
- id_regwrite_i / id_memread_i  in  1  RegWrite / MemRead of the ID instruction.
- br_taken_i  in  1  taken branch resolved this cycle.
- pc_write_o  out  1  PC write enable.
- if_id_write_o  out  1  IF/ID write enable.
- if_id_flush_o  out  1  clear IF/ID to a NOP.
- id_ex_bubble_o  out  1  load NOP controls into ID/EX.
- fwd_a_o / fwd_b_o  out  2  EX operand select: 00 = ID/EX data, 10 = EX/MEM result, 01 = WB data.
- rf_byp_a_o / rf_byp_b_o  out  1  ID read of rs / rt must take WB data.
- ex_valid_o, mem_valid_o, wb_valid_o  out  1  scoreboard valid per stage.
- stall_cnt_o / flush_cnt_o  out  CNT_W  saturating cycle counters.

## Operation
- Scoreboard: the EX, MEM and WB entries each hold {valid, dst, regwrite, memread}. The EX entry also holds rs, uses_rs, rt and uses_rt.
- A stage "writes r" when valid && regwrite && dst == r && r != 0.
- Each cycle the entries shift EX→MEM→WB unconditionally; there is no backpressure past EX.
- EX loads the ID fields when id_valid_i && !stall && !squash_ex. Otherwise EX loads valid = 0.
- Load-use stall is asserted when all of the following hold:
  - id_valid_i is high;
  - the EX entry is valid, regwrite, memread, with dst != 0;
  - dst matches rs (with id_uses_rs_i) or rt (with id_uses_rt_i).
- On a stall: pc_write_o = 0, if_id_write_o = 0, id_ex_bubble_o = 1, and the EX entry becomes a bubble.
- Forwarding for EX operand A (B identical, using rt):
  - if MEM writes ex_rs: 10;
  - else if WB writes ex_rs: 01;
  - else 00.
  - Only asserted when the EX entry is valid and uses_rs. MEM has priority over WB.
- RF bypass: rf_byp_a_o = id_uses_rs_i && WB writes id_rs_i. rf_byp_b_o is the same using rt.
- Branch flush on br_taken_i:
  - FLUSH_DEPTH ≥ 1: if_id_flush_o = 1.
  - FLUSH_DEPTH ≥ 2: EX loads a bubble and id_ex_bubble_o = 1.
  - FLUSH_DEPTH = 3: the MEM entry loads valid = 0.
- A flush overrides a stall in the same cycle: pc_write_o = 1, if_id_write_o = 1, and the stall is not counted.
- Counters: each counter saturates at all-ones.
  - stall_cnt_o increments every cycle the stall is effective.
  - flush_cnt_o increments every cycle br_taken_i is high.

## Timing
- Reset values:
  - all valid = 0, all fwd = 00, rf_byp = 0;
  - pc_write_o = 1, if_id_write_o = 1;
  - if_id_flush_o = 0, id_ex_bubble_o = 0;
  - both counters = 0.
- A reset asserted mid-stall or mid-flush clears everything on that edge.
- Stall, flush, bubble and bypass outputs are combinational from the registered scoreboard plus the ID/branch inputs, valid within the same cycle.
- fwd_* outputs depend only on registered state.
- A single load-use hazard stalls exactly 1 cycle. Two cycles later the dependent instruction, now in EX, sees fwd = 01.
- The scoreboard and counters update on the rising edge after the decision.

## Test plan
- Reset: hold rst_i for 2 cycles with random inputs → valids 0, counters 0, pc_write_o = 1, fwd_a_o = 00.
- Back-to-back ALU dependence:
  - "add $3" enters EX followed by "sub $5,$3,$4" → next cycle fwd_a_o = 10.
  - With one unrelated instruction between them → fwd_a_o = 01.
  - If both MEM and WB write $3 → fwd_a_o = 10.
- Load-use:
  - "lw $2" in EX while "add $4,$2,$5" is in ID → for one cycle pc_write_o = 0, if_id_write_o = 0, id_ex_bubble_o = 1.
  - Afterwards stall_cnt_o = 1; two cycles later fwd_a_o = 01.
- Register 0: producer with dst = 0 followed by a consumer of $0 → fwd = 00, no stall, rf_byp = 0.
- Flush with FLUSH_DEPTH = 3: br_taken_i asserted in the same cycle as a load-use condition →
  - if_id_flush_o = 1, pc_write_o = 1;
  - next cycle ex_valid_o = 0 and mem_valid_o = 0;
  - flush_cnt_o = 1, stall_cnt_o unchanged.
- Saturation with CNT_W = 4: hold a stall condition for 20 cycles → stall_cnt_o stops at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for a five-stage pipeline. It tracks in-flight destinations
// in EX/MEM/WB and drives forwarding, RF bypass, load-use stall, branch flush and event counters.
module pipe_hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int FLUSH_DEPTH = 3,
  parameter int CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rs_i,
  input  logic              id_uses_rt_i,
  input  logic [REG_AW-1:0] id_dst_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              br_taken_i,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic              if_id_flush_o,
  output logic              id_ex_bubble_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              rf_byp_a_o,
  output logic              rf_byp_b_o,
  output logic              ex_valid_o,
  output logic              mem_valid_o,
  output logic              wb_valid_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              regwrite;
    logic              memread;
  } stage_t;

  localparam logic [REG_AW-1:0] ZERO_REG = '0;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  stage_t            ex_r, mem_r, wb_r;
  stage_t            ex_next_s, mem_next_s;
  logic [REG_AW-1:0] ex_rs_r, ex_rt_r;
  logic              ex_uses_rs_r, ex_uses_rt_r;
  logic [CNT_W-1:0]  stall_cnt_r, flush_cnt_r;
  logic              load_use_s, branch_s, stall_s, squash_ex_s, squash_mem_s;

  // Register 0 never counts as a produced value, so it can never forward or stall.
  function automatic logic writes_reg(input stage_t st, input logic [REG_AW-1:0] r);
    return st.valid && st.regwrite && (st.dst == r) && (r != ZERO_REG);
  endfunction

  // Load-use detection and branch squash decisions; a taken branch wins over a stall
  always_comb begin
    load_use_s = 1'b0;
    if (ex_r.valid && ex_r.regwrite && ex_r.memread && (ex_r.dst != ZERO_REG)) begin
      load_use_s = id_valid_i &&
                   ((id_uses_rs_i && (id_rs_i == ex_r.dst)) ||
                    (id_uses_rt_i && (id_rt_i == ex_r.dst)));
    end else begin
      load_use_s = 1'b0;
    end
    branch_s     = br_taken_i && !rst_i;
    stall_s      = load_use_s && !branch_s && !rst_i;
    squash_ex_s  = branch_s && (FLUSH_DEPTH >= 2);
    squash_mem_s = branch_s && (FLUSH_DEPTH >= 3);
  end

  // Next scoreboard contents for EX and MEM
  always_comb begin
    ex_next_s  = '0;
    mem_next_s = ex_r;
    if (id_valid_i && !stall_s && !squash_ex_s) begin
      ex_next_s = {1'b1, id_dst_i, id_regwrite_i, id_memread_i};
    end else begin
      ex_next_s = '0;
    end
    if (squash_mem_s) begin
      mem_next_s.valid = 1'b0;
    end else begin
      mem_next_s.valid = ex_r.valid;
    end
  end

  // EX operand selects: MEM result is younger than WB data and takes priority
  always_comb begin
    fwd_a_o = 2'b00;
    fwd_b_o = 2'b00;
    if (ex_r.valid && ex_uses_rs_r) begin
      if (writes_reg(mem_r, ex_rs_r))     fwd_a_o = 2'b10;
      else if (writes_reg(wb_r, ex_rs_r)) fwd_a_o = 2'b01;
      else                                fwd_a_o = 2'b00;
    end else begin
      fwd_a_o = 2'b00;
    end
    if (ex_r.valid && ex_uses_rt_r) begin
      if (writes_reg(mem_r, ex_rt_r))     fwd_b_o = 2'b10;
      else if (writes_reg(wb_r, ex_rt_r)) fwd_b_o = 2'b01;
      else                                fwd_b_o = 2'b00;
    end else begin
      fwd_b_o = 2'b00;
    end
  end

  assign pc_write_o     = !stall_s;
  assign if_id_write_o  = !stall_s;
  assign if_id_flush_o  = branch_s;
  assign id_ex_bubble_o = stall_s || squash_ex_s;
  assign rf_byp_a_o     = id_uses_rs_i && writes_reg(wb_r, id_rs_i);
  assign rf_byp_b_o     = id_uses_rt_i && writes_reg(wb_r, id_rt_i);
  assign ex_valid_o     = ex_r.valid;
  assign mem_valid_o    = mem_r.valid;
  assign wb_valid_o     = wb_r.valid;
  assign stall_cnt_o    = stall_cnt_r;
  assign flush_cnt_o    = flush_cnt_r;

  // Scoreboard shift and saturating counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_r         <= '0;
      mem_r        <= '0;
      wb_r         <= '0;
      ex_rs_r      <= '0;
      ex_rt_r      <= '0;
      ex_uses_rs_r <= 1'b0;
      ex_uses_rt_r <= 1'b0;
      stall_cnt_r  <= '0;
      flush_cnt_r  <= '0;
    end else begin
      ex_r         <= ex_next_s;
      mem_r        <= mem_next_s;
      wb_r         <= mem_r;
      ex_rs_r      <= id_rs_i;
      ex_rt_r      <= id_rt_i;
      ex_uses_rs_r <= id_uses_rs_i;
      ex_uses_rt_r <= id_uses_rt_i;
      if (stall_s && (stall_cnt_r != CNT_MAX)) stall_cnt_r <= stall_cnt_r + CNT_ONE;
      if (branch_s && (flush_cnt_r != CNT_MAX)) flush_cnt_r <= flush_cnt_r + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a driver pushes predicted outputs from an
// instruction-level pipeline model, a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;
  localparam int AW   = 5;
  localparam int FD   = 3;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memread, br_taken;
  logic [AW-1:0] id_rs, id_rt, id_dst;
  logic          pc_write, if_id_write, if_id_flush, id_ex_bubble;
  logic [1:0]    fwd_a, fwd_b;
  logic          rf_byp_a, rf_byp_b, ex_valid, mem_valid, wb_valid;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.REG_AW(AW), .FLUSH_DEPTH(FD), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_uses_rs_i(id_uses_rs), .id_uses_rt_i(id_uses_rt), .id_dst_i(id_dst),
    .id_regwrite_i(id_regwrite), .id_memread_i(id_memread), .br_taken_i(br_taken),
    .pc_write_o(pc_write), .if_id_write_o(if_id_write), .if_id_flush_o(if_id_flush),
    .id_ex_bubble_o(id_ex_bubble), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b),
    .rf_byp_a_o(rf_byp_a), .rf_byp_b_o(rf_byp_b), .ex_valid_o(ex_valid),
    .mem_valid_o(mem_valid), .wb_valid_o(wb_valid), .stall_cnt_o(stall_cnt),
    .flush_cnt_o(flush_cnt)
  );

  typedef struct {
    bit v; bit [4:0] rs; bit urs; bit [4:0] rt; bit urt; bit [4:0] dst; bit rw; bit mr;
  } ins_t;
  typedef struct {
    bit pcw; bit ifw; bit flush; bit bub; bit [1:0] fa; bit [1:0] fb;
    bit ra; bit rb; bit exv; bit memv; bit wbv; int sc; int fc;
  } exp_t;

  ins_t pipe [3];          // 0 = EX, 1 = MEM, 2 = WB
  ins_t nop_i;
  ins_t cur;
  bit   cur_rst, cur_br;
  int   stall_cnt_m, flush_cnt_m;
  exp_t expq [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic ins_t mk(bit v, bit [4:0] rs, bit urs, bit [4:0] rt, bit urt,
                              bit [4:0] dst, bit rw, bit mr);
    ins_t i;
    i.v = v; i.rs = rs; i.urs = urs; i.rt = rt; i.urt = urt; i.dst = dst; i.rw = rw; i.mr = mr;
    return i;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t i;
    i.v   = ($urandom_range(0, 3) != 0);
    i.rs  = 5'($urandom_range(0, 3));
    i.rt  = 5'($urandom_range(0, 3));
    i.dst = 5'($urandom_range(0, 3));
    i.urs = 1'($urandom_range(0, 1));
    i.urt = 1'($urandom_range(0, 1));
    i.rw  = ($urandom_range(0, 3) != 0);
    i.mr  = ($urandom_range(0, 2) == 0);
    return i;
  endfunction

  function automatic bit writes(ins_t s, bit [4:0] r);
    return s.v && s.rw && (s.dst == r) && (r != 5'd0);
  endfunction

  function automatic bit [1:0] fwd_sel(bit use_it, bit [4:0] r);
    if (!pipe[0].v || !use_it) return 2'b00;
    if (writes(pipe[1], r)) return 2'b10;
    if (writes(pipe[2], r)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit load_use();
    ins_t e = pipe[0];
    if (!(cur.v && e.v && e.rw && e.mr && e.dst != 5'd0)) return 1'b0;
    return (cur.urs && cur.rs == e.dst) || (cur.urt && cur.rt == e.dst);
  endfunction

  function automatic exp_t predict();
    exp_t e;
    bit br, stall;
    br      = cur_br && !cur_rst;
    stall   = load_use() && !br && !cur_rst;
    e.pcw   = !stall;
    e.ifw   = !stall;
    e.flush = br;
    e.bub   = stall || (br && FD >= 2);
    e.fa    = fwd_sel(pipe[0].urs, pipe[0].rs);
    e.fb    = fwd_sel(pipe[0].urt, pipe[0].rt);
    e.ra    = cur.urs && writes(pipe[2], cur.rs);
    e.rb    = cur.urt && writes(pipe[2], cur.rt);
    e.exv   = pipe[0].v;
    e.memv  = pipe[1].v;
    e.wbv   = pipe[2].v;
    e.sc    = stall_cnt_m;
    e.fc    = flush_cnt_m;
    return e;
  endfunction

  function automatic void advance();
    bit br, stall;
    br    = cur_br && !cur_rst;
    stall = load_use() && !br && !cur_rst;
    if (cur_rst) begin
      for (int i = 0; i < 3; i++) pipe[i] = nop_i;
      stall_cnt_m = 0;
      flush_cnt_m = 0;
    end else begin
      if (stall && stall_cnt_m < CMAX) stall_cnt_m++;
      if (br && flush_cnt_m < CMAX) flush_cnt_m++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (br && FD == 3) pipe[1].v = 1'b0;
      if (cur.v && !stall && !(br && FD >= 2)) pipe[0] = cur;
      else pipe[0] = nop_i;
    end
  endfunction

  task automatic dcheck(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Ends the current cycle, then drives a new one and records its prediction.
  task automatic apply(bit r, ins_t ins, bit br);
    @(posedge clk);
    advance();
    #1;
    cur = ins; cur_rst = r; cur_br = br;
    rst = r; id_valid = ins.v; id_rs = ins.rs; id_uses_rs = ins.urs; id_rt = ins.rt;
    id_uses_rt = ins.urt; id_dst = ins.dst; id_regwrite = ins.rw; id_memread = ins.mr;
    br_taken = br;
    #1;
    expq.push_back(predict());
  endtask

  // Monitor: compares every presented cycle against the oldest prediction
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      dcheck("pc_write", pc_write, e.pcw);
      dcheck("if_id_write", if_id_write, e.ifw);
      dcheck("if_id_flush", if_id_flush, e.flush);
      dcheck("id_ex_bubble", id_ex_bubble, e.bub);
      dcheck("fwd_a", fwd_a, e.fa);
      dcheck("fwd_b", fwd_b, e.fb);
      dcheck("rf_byp_a", rf_byp_a, e.ra);
      dcheck("rf_byp_b", rf_byp_b, e.rb);
      dcheck("ex_valid", ex_valid, e.exv);
      dcheck("mem_valid", mem_valid, e.memv);
      dcheck("wb_valid", wb_valid, e.wbv);
      dcheck("stall_cnt", stall_cnt, e.sc);
      dcheck("flush_cnt", flush_cnt, e.fc);
    end
  end

  initial begin
    ins_t add_dep;
    rst = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_dst = '0; id_regwrite = 1'b0; id_memread = 1'b0; br_taken = 1'b0;
    cur = nop_i; cur_rst = 1'b1; cur_br = 1'b0;

    apply(1'b1, rnd_ins(), 1'($urandom_range(0, 1)));
    apply(1'b1, rnd_ins(), 1'($urandom_range(0, 1)));
    dcheck("rst_ex_valid", ex_valid, 0);
    dcheck("rst_wb_valid", wb_valid, 0);
    dcheck("rst_stall_cnt", stall_cnt, 0);
    dcheck("rst_pc_write", pc_write, 1);
    dcheck("rst_fwd_a", fwd_a, 0);

    apply(1'b0, mk(1, 1, 1, 2, 1, 3, 1, 0), 1'b0);     // add $3,$1,$2
    apply(1'b0, mk(1, 3, 1, 4, 1, 5, 1, 0), 1'b0);     // sub $5,$3,$4
    apply(1'b0, nop_i, 1'b0);
    dcheck("alu_fwd_mem", fwd_a, 2);
    dcheck("alu_fwd_b_none", fwd_b, 0);

    apply(1'b0, mk(1, 1, 1, 2, 1, 3, 1, 0), 1'b0);
    apply(1'b0, mk(1, 8, 1, 9, 1, 7, 1, 0), 1'b0);     // unrelated
    apply(1'b0, mk(1, 3, 1, 4, 1, 5, 1, 0), 1'b0);
    apply(1'b0, nop_i, 1'b0);
    dcheck("alu_fwd_wb", fwd_a, 1);

    apply(1'b0, mk(1, 1, 1, 2, 1, 3, 1, 0), 1'b0);
    apply(1'b0, mk(1, 1, 1, 2, 1, 3, 1, 0), 1'b0);
    apply(1'b0, mk(1, 3, 1, 4, 1, 5, 1, 0), 1'b0);
    apply(1'b0, nop_i, 1'b0);
    dcheck("alu_fwd_mem_prio", fwd_a, 2);

    add_dep = mk(1, 2, 1, 5, 1, 4, 1, 0);              // add $4,$2,$5
    apply(1'b0, mk(1, 1, 1, 0, 0, 2, 1, 1), 1'b0);     // lw $2,0($1)
    apply(1'b0, add_dep, 1'b0);
    dcheck("lu_pc_write", pc_write, 0);
    dcheck("lu_if_id_write", if_id_write, 0);
    dcheck("lu_bubble", id_ex_bubble, 1);
    apply(1'b0, add_dep, 1'b0);
    dcheck("lu_released", pc_write, 1);
    dcheck("lu_stall_cnt", stall_cnt, 1);
    apply(1'b0, nop_i, 1'b0);
    dcheck("lu_fwd_wb", fwd_a, 1);

    apply(1'b0, mk(1, 1, 1, 0, 0, 0, 1, 1), 1'b0);     // lw $0
    apply(1'b0, mk(1, 0, 1, 0, 1, 6, 1, 0), 1'b0);
    dcheck("r0_no_stall", pc_write, 1);
    apply(1'b0, mk(1, 0, 1, 0, 1, 7, 1, 0), 1'b0);
    dcheck("r0_fwd_a", fwd_a, 0);
    dcheck("r0_fwd_b", fwd_b, 0);
    apply(1'b0, mk(1, 0, 1, 0, 1, 8, 1, 0), 1'b0);
    dcheck("r0_rf_byp_a", rf_byp_a, 0);

    apply(1'b0, mk(1, 1, 1, 0, 0, 2, 1, 1), 1'b0);     // lw $2
    apply(1'b0, add_dep, 1'b1);                        // taken branch + load-use
    dcheck("fl_if_id_flush", if_id_flush, 1);
    dcheck("fl_pc_write", pc_write, 1);
    apply(1'b0, nop_i, 1'b0);
    dcheck("fl_ex_valid", ex_valid, 0);
    dcheck("fl_mem_valid", mem_valid, 0);
    dcheck("fl_flush_cnt", flush_cnt, 1);
    dcheck("fl_stall_cnt", stall_cnt, 1);

    for (int i = 0; i < 40; i++) apply(1'b0, mk(1, 2, 1, 0, 0, 2, 1, 1), 1'b0);  // lw $2,0($2)
    apply(1'b0, nop_i, 1'b0);
    dcheck("sat_stall_cnt", stall_cnt, 15);

    apply(1'b1, rnd_ins(), 1'($urandom_range(0, 1)));
    apply(1'b1, rnd_ins(), 1'($urandom_range(0, 1)));
    dcheck("rst2_mem_valid", mem_valid, 0);
    dcheck("rst2_stall_cnt", stall_cnt, 0);
    dcheck("rst2_flush_cnt", flush_cnt, 0);
    dcheck("rst2_if_id_write", if_id_write, 1);

    for (int i = 0; i < 600; i++)
      apply(($urandom_range(0, 63) == 0), rnd_ins(), ($urandom_range(0, 7) == 0));

    repeat (3) @(posedge clk);
    dcheck("queue_drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
